irq_dispatch: RTL and testbench

- Consumer side of the CP0 interrupt priority path.
- Synchronises and latches eight external interrupt lines into a pending register and applies the CP0 mask and global enable.
- Resolves the highest-priority request as a one-hot grant (bit 7 highest), decodes it to a binary interrupt ID, and runs a request/acknowledge/end-of-interrupt handshake with the CP0 exception logic.
- Sits between device interrupt pins and the CP0 Cause/EPC entry logic.

---
 rtl/irq_dispatch_pkg.sv | 18 +
 rtl/irq_onehot_to_bin.sv | 22 ++
 rtl/irq_dispatch.sv | 134 +++++++++++++
 tb/tb_irq_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_dispatch_pkg.sv
// Shared CP0 interrupt definitions.
// Holds the interrupt line count, the interrupt ID width, the default
// edge/level selection and the dispatch FSM state encoding.
package irq_dispatch_pkg;

   localparam int unsigned IRQ_N    = 8;
   localparam int unsigned IRQ_ID_W = 3;

   // 1 = rising-edge triggered (latched), 0 = level triggered
   localparam logic [IRQ_N-1:0] IRQ_EDGE_MASK_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_onehot_to_bin.sv
// One-hot to binary decoder for the interrupt grant vector.
// Ports:
//   onehot : one-hot (or all-zero) grant vector
//   bin    : binary index of the set bit, 0 when onehot is all-zero
module irq_onehot_to_bin
   import irq_dispatch_pkg::*;
(
   input  logic [IRQ_N-1:0]    onehot,
   output logic [IRQ_ID_W-1:0] bin
);

   // OR of the indices of all set bits; exact for a one-hot input.
   always_comb begin
      bin = '0;
      for (int i = 0; i < IRQ_N; i++) begin
         if (onehot[i]) begin
            bin = bin | IRQ_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_dispatch.sv
// CP0 interrupt dispatcher.
// Synchronises eight device interrupt lines, latches them into a pending
// register, masks them with Status.IM/IE, picks the highest-priority line
// (bit 7 highest) and runs a request/ack/EOI handshake with CP0.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   irq_in       : raw device interrupt lines (asynchronous)
//   irq_mask     : Status.IM, 1 = line enabled
//   irq_ie       : Status.IE global enable
//   irq_ack      : CP0 took the exception for the current request
//   irq_eoi      : handler finished (ERET)
//   irq_req      : request to CP0 (REQ state)
//   irq_id       : binary ID of requested / in-service line
//   irq_onehot   : one-hot grant of requested / in-service line
//   irq_pending  : pending lines before masking (Cause.IP)
//   irq_busy     : handler in service (SERVICE state)
module irq_dispatch
   import irq_dispatch_pkg::*;
#(
   parameter int unsigned      N_IRQ     = IRQ_N,
   parameter int unsigned      ID_W      = IRQ_ID_W,
   parameter logic [N_IRQ-1:0] EDGE_MASK = IRQ_EDGE_MASK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [N_IRQ-1:0] irq_mask,
   input  logic             irq_ie,
   input  logic             irq_ack,
   input  logic             irq_eoi,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_IRQ-1:0] irq_onehot,
   output logic [N_IRQ-1:0] irq_pending,
   output logic             irq_busy
);

   logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]  id_q, id_d;
   irq_state_e       state_q, state_d;

   logic [N_IRQ-1:0] elig;
   logic [N_IRQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic [N_IRQ-1:0] clr;
   logic             found;

   assign elig = pend_q & irq_mask & {N_IRQ{irq_ie}};

   // First set bit scanning down from the MSB.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (elig[i] && !found) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   irq_onehot_to_bin u_dec (
      .onehot (gnt),
      .bin    (gnt_id)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      clr     = '0;
      unique case (state_q)
         IDLE: begin
            if (|elig) begin
               grant_d = gnt;
               id_d    = gnt_id;
               state_d = REQ;
            end
         end
         REQ: begin
            // Grant frozen here; ack wins over a simultaneous eoi.
            if (irq_ack) begin
               clr     = grant_q & EDGE_MASK;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_eoi) begin
               grant_d = '0;
               id_d    = '0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            id_d    = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Edge lines: a new edge beats a same-cycle ack clear. Level lines track s2.
   assign pend_d = (EDGE_MASK & ((pend_q & ~clr) | (sync2_q & ~sync3_q)))
                 | (~EDGE_MASK & sync2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         pend_q  <= '0;
         grant_q <= '0;
         id_q    <= '0;
         state_q <= IDLE;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         pend_q  <= pend_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         state_q <= state_d;
      end
   end

   assign irq_req     = (state_q == REQ);
   assign irq_busy    = (state_q == SERVICE);
   assign irq_onehot  = grant_q;
   assign irq_id      = id_q;
   assign irq_pending = pend_q;

endmodule

// File: tb/tb_irq_dispatch.sv
module tb_irq_dispatch;

   typedef struct {
      logic [2:0] id;
      logic [7:0] oh;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] irq_mask = 8'hFF;
   logic       irq_ie = 1'b1;

   // main instance: all lines edge triggered
   logic [7:0] irq_in = '0;
   logic       irq_ack = 1'b0, irq_eoi = 1'b0;
   logic       req, busy;
   logic [2:0] id;
   logic [7:0] onehot, pending;

   // second instance: line 0 level triggered
   logic [7:0] irq_in_l = '0;
   logic       ack_l = 1'b0, eoi_l = 1'b0;
   logic       req_l, busy_l;
   logic [2:0] id_l;
   logic [7:0] onehot_l, pending_l;

   int   tests = 0;
   int   fails = 0;
   exp_t q_m[$];
   exp_t q_l[$];
   exp_t e_m, e_l;
   logic req_prev = 1'b0, req_l_prev = 1'b0;

   always #5 clk = ~clk;

   irq_dispatch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .irq_ie      (irq_ie),
      .irq_ack     (irq_ack),
      .irq_eoi     (irq_eoi),
      .irq_req     (req),
      .irq_id      (id),
      .irq_onehot  (onehot),
      .irq_pending (pending),
      .irq_busy    (busy)
   );

   irq_dispatch #(.EDGE_MASK(8'hFE)) dut_l (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in_l),
      .irq_mask    (irq_mask),
      .irq_ie      (irq_ie),
      .irq_ack     (ack_l),
      .irq_eoi     (eoi_l),
      .irq_req     (req_l),
      .irq_id      (id_l),
      .irq_onehot  (onehot_l),
      .irq_pending (pending_l),
      .irq_busy    (busy_l)
   );

   // Monitor: every new request is compared against the next expected grant.
   always @(negedge clk) begin
      if (req && !req_prev) begin
         tests++;
         if (q_m.size() == 0) begin
            fails++;
            $display("FAIL unexpected_req_main: got id=%0d onehot=%02h, none expected", id, onehot);
         end else begin
            e_m = q_m.pop_front();
            if (id !== e_m.id || onehot !== e_m.oh) begin
               fails++;
               $display("FAIL grant_main: got id=%0d onehot=%02h, expected id=%0d onehot=%02h",
                        id, onehot, e_m.id, e_m.oh);
            end
         end
      end
      if (req_l && !req_l_prev) begin
         tests++;
         if (q_l.size() == 0) begin
            fails++;
            $display("FAIL unexpected_req_lvl: got id=%0d onehot=%02h, none expected",
                     id_l, onehot_l);
         end else begin
            e_l = q_l.pop_front();
            if (id_l !== e_l.id || onehot_l !== e_l.oh) begin
               fails++;
               $display("FAIL grant_lvl: got id=%0d onehot=%02h, expected id=%0d onehot=%02h",
                        id_l, onehot_l, e_l.id, e_l.oh);
            end
         end
      end
      req_prev   <= req;
      req_l_prev <= req_l;
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_m(input int n);
      exp_t e;
      e.id = 3'(n);
      e.oh = 8'h01 << n;
      q_m.push_back(e);
   endtask

   task automatic push_l(input int n);
      exp_t e;
      e.id = 3'(n);
      e.oh = 8'h01 << n;
      q_l.push_back(e);
   endtask

   task automatic pulse_m(input logic [7:0] v);
      irq_in = v;
      step();
      irq_in = '0;
   endtask

   task automatic wait_req(input bit lvl);
      int n = 0;
      while (!(lvl ? req_l : req) && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL wait_req(lvl=%0d): got no request, expected one within 20 cycles", lvl);
      end
   endtask

   task automatic ack_m();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic eoi_m();
      irq_eoi = 1'b1;
      step();
      irq_eoi = 1'b0;
   endtask

   task automatic ack_lv();
      ack_l = 1'b1;
      step();
      ack_l = 1'b0;
   endtask

   task automatic eoi_lv();
      eoi_l = 1'b1;
      step();
      eoi_l = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #2;
      chk("rst_req", {31'd0, req}, 0);
      chk("rst_outs", {15'd0, busy, id, onehot, pending}, 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // 1: single pulse latency and handshake
      irq_in = 8'h08;
      push_m(3);
      step();                       // edge k
      irq_in = '0;
      step();                       // k+1
      chk("t1_pend_early", {24'd0, pending}, 8'h00);
      step();                       // k+2
      chk("t1_pend", {24'd0, pending}, 8'h08);
      chk("t1_req_early", {31'd0, req}, 0);
      step();                       // k+3
      chk("t1_req", {31'd0, req}, 1);
      ack_m();
      chk("t1_pend_ack", {24'd0, pending}, 8'h00);
      chk("t1_busy", {31'd0, busy}, 1);
      chk("t1_req_svc", {31'd0, req}, 0);
      eoi_m();
      chk("t1_busy_eoi", {31'd0, busy}, 0);
      chk("t1_grant_clr", {21'd0, id, onehot}, 0);
      step();
      chk("t1_req_after", {31'd0, req}, 0);

      // 2: priority order 7, 5, 1; first ack carries a simultaneous eoi
      pulse_m(8'hA2);
      push_m(7);
      push_m(5);
      push_m(1);
      wait_req(0);
      irq_ack = 1'b1;
      irq_eoi = 1'b1;
      step();
      irq_ack = 1'b0;
      irq_eoi = 1'b0;
      chk("t2_ack_wins", {30'd0, busy, req}, 2'b10);
      chk("t2_pend", {24'd0, pending}, 8'h22);
      eoi_m();
      wait_req(0);
      ack_m();
      eoi_m();
      wait_req(0);
      ack_m();
      eoi_m();

      // 3: no preemption while in REQ
      pulse_m(8'h04);
      push_m(2);
      wait_req(0);
      pulse_m(8'h40);
      step(4);
      chk("t3_id_frozen", {21'd0, id, onehot}, {21'd0, 3'd2, 8'h04});
      chk("t3_pend", {24'd0, pending}, 8'h44);
      push_m(6);
      ack_m();
      eoi_m();
      wait_req(0);
      ack_m();
      eoi_m();

      // 4: mask and global enable gating
      irq_mask = 8'hF7;
      pulse_m(8'h08);
      step(3);
      chk("t4_pend_masked", {24'd0, pending}, 8'h08);
      chk("t4_req_masked", {31'd0, req}, 0);
      push_m(3);
      irq_mask = 8'hFF;
      step();
      chk("t4_req_unmask", {31'd0, req}, 1);
      ack_m();
      eoi_m();
      irq_ie = 1'b0;
      pulse_m(8'h10);
      step(3);
      chk("t4_pend_ie0", {24'd0, pending}, 8'h10);
      chk("t4_req_ie0", {31'd0, req}, 0);
      push_m(4);
      irq_ie = 1'b1;
      wait_req(0);
      ack_m();
      eoi_m();

      // 5: level-triggered line 0 on the second instance
      irq_in_l = 8'h01;
      push_l(0);
      wait_req(1);
      ack_lv();
      chk("t5_busy", {31'd0, busy_l}, 1);
      chk("t5_pend_kept", {24'd0, pending_l}, 8'h01);
      push_l(0);
      eoi_lv();
      wait_req(1);
      ack_lv();
      irq_in_l = '0;
      step(2);
      chk("t5_pend_hold", {24'd0, pending_l}, 8'h01);
      step();
      chk("t5_pend_drop", {24'd0, pending_l}, 8'h00);
      eoi_lv();
      step(3);
      chk("t5_no_rereq", {31'd0, req_l}, 0);

      // 6: asynchronous reset in SERVICE with pending lines
      pulse_m(8'h80);
      push_m(7);
      wait_req(0);
      ack_m();
      pulse_m(8'h11);
      step(2);
      chk("t6_pend", {24'd0, pending}, 8'h11);
      chk("t6_busy", {31'd0, busy}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_main", {14'd0, req, busy, id, onehot, pending}, 0);
      chk("t6_rst_lvl", {14'd0, req_l, busy_l, id_l, onehot_l, pending_l}, 0);
      #3;
      rst_n = 1'b1;
      step(6);
      chk("t6_pend_after", {24'd0, pending}, 8'h00);
      chk("t6_req_after", {30'd0, req, busy}, 0);

      step(2);
      chk("q_main_empty", q_m.size(), 0);
      chk("q_lvl_empty", q_l.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
